pipe1_rr_sched: RTL and testbench

- Round-robin scheduler that shares the 3-stage arithmetic pipeline F = ((A+B)+(C-D))*D between two requesters.
- Accepts operand sets over valid/ready handshakes and drives the pipeline's A/B/C/D inputs.
- Tracks each issued operation through a 3-deep valid/tag shadow pipeline.
- Returns each result tagged with the requester that issued it.
- Sits between the two client blocks and the free-running pipeline. The pipeline has no stall or enable, so results cannot be back-pressured.

---
 rtl/pipe1_rr_sched.sv | 115 +++++++++++
 tb/tb_pipe1_rr_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe1_rr_sched.sv
// Round-robin front end sharing one free-running 3-stage pipeline between two
// requesters; a valid/tag shadow pipeline routes each result back to its owner.
module pipe1_rr_sched #(
  parameter int N       = 10,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 2,
  localparam int CW     = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_a,
  input  logic [N-1:0]  req0_b,
  input  logic [N-1:0]  req0_c,
  input  logic [N-1:0]  req0_d,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_a,
  input  logic [N-1:0]  req1_b,
  input  logic [N-1:0]  req1_c,
  input  logic [N-1:0]  req1_d,
  output logic [N-1:0]  pipe_a,
  output logic [N-1:0]  pipe_b,
  output logic [N-1:0]  pipe_c,
  output logic [N-1:0]  pipe_d,
  input  logic [N-1:0]  pipe_f,
  output logic          res_valid,
  output logic          res_id,
  output logic [N-1:0]  res_f,
  output logic [CW-1:0] out0_cnt,
  output logic [CW-1:0] out1_cnt,
  output logic          busy
);

  typedef enum logic {PREF0 = 1'b0, PREF1 = 1'b1} ptr_t;

  ptr_t         ptr;
  logic [LAT:1] sv;
  logic [LAT:1] sid;
  logic         elig0;
  logic         elig1;
  logic         gnt_any;
  logic         gnt_id;
  logic         issue;
  logic         retire0;
  logic         retire1;

  // Counts are registered, so a retirement this cycle cannot free a slot until the next one.
  assign elig0 = req0_valid && (out0_cnt < CW'(MAX_OUT));
  assign elig1 = req1_valid && (out1_cnt < CW'(MAX_OUT));

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (elig0 && elig1) begin
      gnt_any = 1'b1;
      gnt_id  = (ptr == PREF1);
    end else if (elig0) begin
      gnt_any = 1'b1;
    end else if (elig1) begin
      gnt_any = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  assign req0_ready = gnt_any && !gnt_id && !rst;
  assign req1_ready = gnt_any &&  gnt_id && !rst;
  assign issue      = req0_ready || req1_ready;

  assign pipe_a = gnt_id ? req1_a : req0_a;
  assign pipe_b = gnt_id ? req1_b : req0_b;
  assign pipe_c = gnt_id ? req1_c : req0_c;
  assign pipe_d = gnt_id ? req1_d : req0_d;

  assign res_valid = sv[LAT];
  assign res_id    = sid[LAT];
  assign res_f     = pipe_f;
  assign busy      = |sv;
  assign retire0   = sv[LAT] && !sid[LAT];
  assign retire1   = sv[LAT] &&  sid[LAT];

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + CW'(1);
      2'b01:   return cnt - CW'(1);
      default: return cnt;
    endcase
  endfunction

  // The shadow shifts every cycle because the pipeline it mirrors never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      sv       <= '0;
      sid      <= '0;
      ptr      <= PREF0;
      out0_cnt <= '0;
      out1_cnt <= '0;
    end else begin
      sv[1]  <= issue;
      sid[1] <= gnt_id;
      for (int k = 2; k <= LAT; k++) begin
        sv[k]  <= sv[k-1];
        sid[k] <= sid[k-1];
      end
      if (issue) begin
        ptr <= gnt_id ? PREF0 : PREF1;
      end
      out0_cnt <= next_cnt(out0_cnt, req0_ready, retire0);
      out1_cnt <= next_cnt(out1_cnt, req1_ready, retire1);
    end
  end

endmodule

// File: tb/tb_pipe1_rr_sched.sv
// Directed bench for pipe1_rr_sched with a behavioural model of the shared
// ((A+B)+(C-D))*D pipeline feeding pipe_f.
module tb_pipe1_rr_sched;

  localparam int N       = 10;
  localparam int LAT     = 3;
  localparam int MAX_OUT = 2;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0]  req0_a, req0_b, req0_c, req0_d;
  logic [N-1:0]  req1_a, req1_b, req1_c, req1_d;
  logic [N-1:0]  pipe_a, pipe_b, pipe_c, pipe_d, pipe_f;
  logic          res_valid, res_id, busy;
  logic [N-1:0]  res_f;
  logic [CW-1:0] out0_cnt, out1_cnt;

  always #5 clk = ~clk;

  pipe1_rr_sched #(.N(N), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_d(req1_d),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
    .pipe_f(pipe_f),
    .res_valid(res_valid), .res_id(res_id), .res_f(res_f),
    .out0_cnt(out0_cnt), .out1_cnt(out1_cnt), .busy(busy)
  );

  // Free-running 3-stage pipeline; it has no reset, so stale data survives a scheduler reset.
  logic [N-1:0] s1_ab, s1_cd, s1_d, s2_sum, s2_d, s3_f;
  always_ff @(posedge clk) begin
    s1_ab  <= pipe_a + pipe_b;
    s1_cd  <= pipe_c - pipe_d;
    s1_d   <= pipe_d;
    s2_sum <= s1_ab + s1_cd;
    s2_d   <= s1_d;
    s3_f   <= s2_sum * s2_d;
  end
  assign pipe_f = s3_f;

  typedef struct {
    logic         rst;
    logic         v0;
    logic [4*N-1:0] op0;
    logic         v1;
    logic [4*N-1:0] op1;
    logic         r0;
    logic         r1;
    logic         rv;
    logic         id;
    int           f;
    int           c0;
    int           c1;
    logic         bz;
  } vec_t;

  localparam logic [4*N-1:0] Z  = '0;
  localparam logic [4*N-1:0] X0 = {10'd3, 10'd4, 10'd10, 10'd2};
  localparam logic [4*N-1:0] P  = {10'd1, 10'd1, 10'd1, 10'd1};
  localparam logic [4*N-1:0] Q  = {10'd2, 10'd0, 10'd5, 10'd3};
  localparam logic [4*N-1:0] W  = {10'd1023, 10'd1, 10'd0, 10'd1};
  localparam logic [4*N-1:0] V5 = {10'd5, 10'd6, 10'd7, 10'd2};

  int compared   = 0;
  int mismatched = 0;
  vec_t vt[22];

  function automatic vec_t mk(input logic rst_i, input logic v0_i, input logic [4*N-1:0] op0_i,
                              input logic v1_i, input logic [4*N-1:0] op1_i,
                              input logic r0_i, input logic r1_i, input logic rv_i,
                              input logic id_i, input int f_i, input int c0_i,
                              input int c1_i, input logic bz_i);
    vec_t v;
    v.rst = rst_i; v.v0 = v0_i; v.op0 = op0_i; v.v1 = v1_i; v.op1 = op1_i;
    v.r0 = r0_i; v.r1 = r1_i; v.rv = rv_i; v.id = id_i; v.f = f_i;
    v.c0 = c0_i; v.c1 = c1_i; v.bz = bz_i;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    req0_valid = v.v0;
    {req0_a, req0_b, req0_c, req0_d} = v.op0;
    req1_valid = v.v1;
    {req1_a, req1_b, req1_c, req1_d} = v.op1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check({tag, ".req0_ready"}, int'(req0_ready), int'(v.r0));
    check({tag, ".req1_ready"}, int'(req1_ready), int'(v.r1));
    check({tag, ".res_valid"},  int'(res_valid),  int'(v.rv));
    check({tag, ".out0_cnt"},   int'(out0_cnt),   v.c0);
    check({tag, ".out1_cnt"},   int'(out1_cnt),   v.c1);
    check({tag, ".busy"},       int'(busy),       int'(v.bz));
    if (v.rv) begin
      check({tag, ".res_id"}, int'(res_id), int'(v.id));
      check({tag, ".res_f"},  int'(res_f),  v.f);
    end
  endtask

  task automatic runRow(input string tag, input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(tag, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst v0 op0 v1 op1 | r0 r1 rv id f c0 c1 busy
    vt[0]  = mk(1, 1, X0, 0, Z,  0, 0, 0, 0, 0,    0, 0, 0);
    vt[1]  = mk(0, 1, X0, 0, Z,  1, 0, 0, 0, 0,    0, 0, 0);
    vt[2]  = mk(0, 0, Z,  0, Z,  0, 0, 0, 0, 0,    1, 0, 1);
    vt[3]  = mk(0, 0, Z,  0, Z,  0, 0, 0, 0, 0,    1, 0, 1);
    vt[4]  = mk(0, 0, Z,  0, Z,  0, 0, 1, 0, 30,   1, 0, 1);
    vt[5]  = mk(0, 0, Z,  0, Z,  0, 0, 0, 0, 0,    0, 0, 0);
    vt[6]  = mk(1, 1, P,  1, Q,  0, 0, 0, 0, 0,    0, 0, 0);
    vt[7]  = mk(0, 1, P,  1, Q,  1, 0, 0, 0, 0,    0, 0, 0);
    vt[8]  = mk(0, 1, P,  1, Q,  0, 1, 0, 0, 0,    1, 0, 1);
    vt[9]  = mk(0, 1, P,  1, Q,  1, 0, 0, 0, 0,    1, 1, 1);
    vt[10] = mk(0, 1, P,  1, Q,  0, 1, 1, 0, 2,    2, 1, 1);
    vt[11] = mk(0, 1, P,  1, Q,  1, 0, 1, 1, 12,   1, 2, 1);
    vt[12] = mk(0, 1, P,  1, Q,  0, 1, 1, 0, 2,    2, 1, 1);
    vt[13] = mk(0, 1, P,  1, Q,  1, 0, 1, 1, 12,   1, 2, 1);
    vt[14] = mk(0, 0, Z,  0, Z,  0, 0, 1, 0, 2,    2, 1, 1);
    vt[15] = mk(0, 0, Z,  0, Z,  0, 0, 1, 1, 12,   1, 1, 1);
    vt[16] = mk(0, 0, Z,  0, Z,  0, 0, 1, 0, 2,    1, 0, 1);
    vt[17] = mk(0, 0, Z,  1, W,  0, 1, 0, 0, 0,    0, 0, 0);
    vt[18] = mk(0, 0, Z,  0, Z,  0, 0, 0, 0, 0,    0, 1, 1);
    vt[19] = mk(0, 0, Z,  0, Z,  0, 0, 0, 0, 0,    0, 1, 1);
    vt[20] = mk(0, 0, Z,  0, Z,  0, 0, 1, 1, 1023, 0, 1, 1);
    vt[21] = mk(0, 0, Z,  0, Z,  0, 0, 0, 0, 0,    0, 0, 0);

    applyStimulus(mk(1, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;

    $display("[TB] table: single op, contention, wrap-around");
    for (int i = 0; i < 22; i++) begin
      runRow($sformatf("row%0d", i), vt[i]);
    end

    // Credit limit with req1 slipping in while req0 is blocked; cycle 4 issues and retires for req0.
    $display("[TB] credit limit sequence");
    runRow("cr.rst", mk(1, 0, Z, 0, Z,  0, 0, 0, 0, 0,  0, 0, 0));
    runRow("cr.c0",  mk(0, 1, P, 0, Z,  1, 0, 0, 0, 0,  0, 0, 0));
    runRow("cr.c1",  mk(0, 1, P, 0, Z,  1, 0, 0, 0, 0,  1, 0, 1));
    runRow("cr.c2",  mk(0, 1, P, 1, V5, 0, 1, 0, 0, 0,  2, 0, 1));
    runRow("cr.c3",  mk(0, 1, P, 0, Z,  0, 0, 1, 0, 2,  2, 1, 1));
    runRow("cr.c4",  mk(0, 1, P, 0, Z,  1, 0, 1, 0, 2,  1, 1, 1));
    runRow("cr.c5",  mk(0, 1, P, 0, Z,  1, 0, 1, 1, 32, 1, 1, 1));
    runRow("cr.c6",  mk(0, 1, P, 0, Z,  0, 0, 0, 0, 0,  2, 0, 1));
    runRow("cr.c7",  mk(0, 1, P, 0, Z,  0, 0, 1, 0, 2,  2, 0, 1));
    runRow("cr.c8",  mk(0, 0, Z, 0, Z,  0, 0, 1, 0, 2,  1, 0, 1));
    runRow("cr.c9",  mk(0, 0, Z, 0, Z,  0, 0, 0, 0, 0,  0, 0, 0));

    // Reset while two ops are in flight and the pointer favours requester 1.
    $display("[TB] reset mid-flight sequence");
    runRow("mf.rst", mk(1, 0, Z, 0, Z,  0, 0, 0, 0, 0,  0, 0, 0));
    runRow("mf.c0",  mk(0, 0, Z, 1, Q,  0, 1, 0, 0, 0,  0, 0, 0));
    runRow("mf.c1",  mk(0, 1, P, 0, Z,  1, 0, 0, 0, 0,  0, 1, 1));
    applyStimulus(mk(1, 1, P, 1, Q, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("mf.c2.req0_ready", int'(req0_ready), 0);
    check("mf.c2.req1_ready", int'(req1_ready), 0);
    @(posedge clk);
    #1;
    for (int i = 3; i < 8; i++) begin
      runRow($sformatf("mf.c%0d", i), mk(0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    runRow("mf.c8",  mk(0, 1, P, 1, Q,  1, 0, 0, 0, 0,  0, 0, 0));
    applyStimulus(mk(0, 0, Z, 0, Z, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
